// File: rtl/sa_feeder_2x2_if.sv
// Write port of the 2x2 array feeder: valid/ready handshake plus buffer address and data.
interface sa_feeder_2x2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 2
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_sel;
  logic                  wr_lane;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid, wr_sel, wr_lane, wr_idx, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_sel, wr_lane, wr_idx, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/sa_feeder_2x2.sv
// Transmit-side sequencer for the 2x2 systolic array.
// It buffers a 2x2 weight block and a 2-lane operand block, preloads the weights
// over FDi, then streams the operands on RD_0/RD_1 with a one-cycle row skew.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | accepting writes, waiting for start
// S_LOAD   | 2 cycles, weights on FDi with load high (row 1 then row 0)
// S_STREAM | DEPTH+2 cycles, skewed operand stream with column strobes
// S_DONE   | 1 cycle completion pulse
module sa_feeder_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sa_feeder_2x2_if.slave        wr,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] RD_0,
  output logic [DATA_WIDTH-1:0] RD_1,
  output logic [DATA_WIDTH-1:0] FDi_0,
  output logic [DATA_WIDTH-1:0] FDi_1,
  output logic                  load,
  output logic                  bd_PE_0,
  output logic                  bd_PE_1
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Counter must hold DEPTH+1; DEPTH <= 2**IDX_W so one extra bit suffices.
  localparam int CNT_W = IDX_W + 1;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  int                    stream_k;

  logic [DATA_WIDTH-1:0] rd_q [2][DEPTH];
  logic [DATA_WIDTH-1:0] rd_d [2][DEPTH];
  logic [DATA_WIDTH-1:0] w_q  [2][2];
  logic [DATA_WIDTH-1:0] w_d  [2][2];

  logic                  wr_ready_q, wr_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load_q, load_d;
  logic                  bd0_q, bd0_d;
  logic                  bd1_q, bd1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] fd0_q, fd0_d;
  logic [DATA_WIDTH-1:0] fd1_q, fd1_d;

  logic                  wr_fire;

  assign wr_fire     = wr.wr_valid & wr_ready_q;
  assign wr.wr_ready = wr_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load        = load_q;
  assign bd_PE_0     = bd0_q;
  assign bd_PE_1     = bd1_q;
  assign RD_0        = rd0_q;
  assign RD_1        = rd1_q;
  assign FDi_0       = fd0_q;
  assign FDi_1       = fd1_q;

  // Buffer write decode; out-of-range operand indices are accepted and dropped.
  always_comb begin
    rd_d = rd_q;
    w_d  = w_q;
    if (wr_fire) begin
      if (!wr.wr_sel) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (int'(wr.wr_idx) == j) rd_d[wr.wr_lane][j] = wr.wr_data;
        end
      end else begin
        w_d[wr.wr_idx[0]][wr.wr_lane] = wr.wr_data;
      end
    end
  end

  // Sequencer: down-counter per phase, phase ends at terminal count zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d = S_STREAM;
          cnt_d   = CNT_W'(DEPTH + 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream position k counts up while the counter counts down.
  assign stream_k = DEPTH + 1 - int'(cnt_d);

  // Output decode from the next state and next buffer contents, so every
  // output is a register and a write committed alongside start is visible.
  always_comb begin
    wr_ready_d = (state_d == S_IDLE);
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load_d     = 1'b0;
    bd0_d      = 1'b0;
    bd1_d      = 1'b0;
    rd0_d      = '0;
    rd1_d      = '0;
    fd0_d      = '0;
    fd1_d      = '0;
    case (state_d)
      S_LOAD: begin
        busy_d = 1'b1;
        load_d = 1'b1;
        if (cnt_d == CNT_W'(1)) begin
          fd0_d = w_d[1][0];
          fd1_d = w_d[1][1];
        end else begin
          fd0_d = w_d[0][0];
          fd1_d = w_d[0][1];
        end
      end
      S_STREAM: begin
        busy_d = 1'b1;
        bd0_d  = (stream_k <= DEPTH);
        bd1_d  = (stream_k >= 1);
        for (int j = 0; j < DEPTH; j++) begin
          if (j == stream_k)     rd0_d = rd_d[0][j];
          if (j == stream_k - 1) rd1_d = rd_d[1][j];
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      for (int l = 0; l < 2; l++) begin
        for (int j = 0; j < DEPTH; j++) rd_q[l][j] <= '0;
        for (int j = 0; j < 2; j++)     w_q[l][j]  <= '0;
      end
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      bd0_q      <= 1'b0;
      bd1_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      fd0_q      <= '0;
      fd1_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      w_q        <= w_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_q     <= load_d;
      bd0_q      <= bd0_d;
      bd1_q      <= bd1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      fd0_q      <= fd0_d;
      fd1_q      <= fd1_d;
    end
  end

endmodule

// File: tb/tb_sa_feeder_2x2.sv
// Bench for sa_feeder_2x2: directed scenarios plus randomized buffer contents,
// checked against a cycle-table reference model of the load/stream sequence.
module tb_sa_feeder_2x2;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic start, busy, done, load, bd0, bd1;
  logic [DW-1:0] rd0, rd1, fd0, fd1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_rd [2][DEPTH];
  logic [DW-1:0] m_w  [2][2];

  always #5 clk = ~clk;

  sa_feeder_2x2_if #(.DATA_WIDTH(DW), .IDX_W(IDX_W)) wif ();

  sa_feeder_2x2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wif),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .RD_0   (rd0),
    .RD_1   (rd1),
    .FDi_0  (fd0),
    .FDi_1  (fd1),
    .load   (load),
    .bd_PE_0(bd0),
    .bd_PE_1(bd1)
  );

  function automatic logic [69:0] obs_vec();
    return {wif.wr_ready, busy, done, load, bd1, bd0, fd1, fd0, rd1, rd0};
  endfunction

  // Expected outputs for cycle c of a sequence (c = 0 means idle).
  function automatic logic [69:0] exp_vec(input int c);
    logic rdy, bsy, dn, ld, b0, b1;
    logic [DW-1:0] r0, r1, f0, f1;
    int k;
    rdy = 1'b0; bsy = 1'b0; dn = 1'b0; ld = 1'b0; b0 = 1'b0; b1 = 1'b0;
    r0 = '0; r1 = '0; f0 = '0; f1 = '0;
    if (c == 0) begin
      rdy = 1'b1;
    end else if (c <= 2) begin
      ld = 1'b1; bsy = 1'b1;
      for (int i = 0; i < 2; i++)
        if (i == 2 - c) begin f0 = m_w[i][0]; f1 = m_w[i][1]; end
    end else if (c <= DEPTH + 4) begin
      k = c - 3;
      bsy = 1'b1;
      b0 = (k <= DEPTH);
      b1 = (k >= 1);
      for (int j = 0; j < DEPTH; j++) begin
        if (j == k)     r0 = m_rd[0][j];
        if (j == k - 1) r1 = m_rd[1][j];
      end
    end else if (c == DEPTH + 5) begin
      dn = 1'b1;
    end
    return {rdy, bsy, dn, ld, b1, b0, f1, f0, r1, r0};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < 2; l++) begin
      for (int j = 0; j < DEPTH; j++) m_rd[l][j] = '0;
      for (int j = 0; j < 2; j++)     m_w[l][j]  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write in an idle cycle, optionally with start raised in the same cycle.
  task automatic wr_word(input logic sel, input logic lane, input logic [IDX_W-1:0] idx,
                         input logic [DW-1:0] data, input bit with_start);
    wif.wr_valid = 1'b1; wif.wr_sel = sel; wif.wr_lane = lane;
    wif.wr_idx = idx; wif.wr_data = data; start = with_start;
    chk("hs_ready", {69'b0, wif.wr_ready}, 70'd1);
    tick();
    wif.wr_valid = 1'b0; start = 1'b0;
    if (!sel) begin
      for (int j = 0; j < DEPTH; j++)
        if (j == int'(idx)) m_rd[lane][j] = data;
    end else begin
      for (int i = 0; i < 2; i++)
        if (i == int'(idx[0])) m_w[i][lane] = data;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks cycles 1..DEPTH+6 after start was sampled; optionally hammers the
  // write port and start while the sequence is running.
  task automatic run_seq(input string nm, input bit interfere);
    for (int c = 1; c <= DEPTH + 6; c++) begin
      chk($sformatf("%s_c%0d", nm, c), obs_vec(), exp_vec(c == DEPTH + 6 ? 0 : c));
      if (interfere && (c == 2 || c == 5 || c == 9)) begin
        wif.wr_valid = 1'b1; wif.wr_sel = 1'b0; wif.wr_lane = 1'b0;
        wif.wr_idx = '0; wif.wr_data = 16'd99; start = 1'b1;
      end
      tick();
      wif.wr_valid = 1'b0; start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_sel = 1'b0; wif.wr_lane = 1'b0;
    wif.wr_idx = '0; wif.wr_data = '0;
    clear_model();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_%0d", i), obs_vec(), {1'b1, 69'b0});
    end
    rst = 1'b1;
    tick();
    chk("after_reset", obs_vec(), exp_vec(0));

    // Directed block with interference during the run, then a replay.
    wr_word(1'b1, 1'b0, 3'd0, 16'd3, 1'b0);
    wr_word(1'b1, 1'b1, 3'd0, 16'd4, 1'b0);
    wr_word(1'b1, 1'b0, 3'd1, 16'd5, 1'b0);
    wr_word(1'b1, 1'b1, 3'd1, 16'd6, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      wr_word(1'b0, 1'b0, 3'(j), 16'(j + 1), 1'b0);
      wr_word(1'b0, 1'b1, 3'(j), 16'(j + 5), 1'b0);
    end
    do_start();
    run_seq("directed", 1'b1);
    chk("no_restart", obs_vec(), exp_vec(0));
    do_start();
    chk("replay_rd0_first", {54'b0, rd0}, 70'd0);
    tick();
    chk("replay_rd0_first_k0", {54'b0, rd0}, 70'd0);
    tick();
    chk("replay_rd0_is_1", {54'b0, rd0}, 70'd1);
    for (int i = 0; i < DEPTH + 4; i++) tick();
    chk("replay_end_idle", obs_vec(), exp_vec(0));

    // Reset in cycle 5 of a sequence.
    do_start();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("prerst_c%0d", c), obs_vec(), exp_vec(c));
      tick();
    end
    rst = 1'b0;
    #1;
    chk("midrst_now", obs_vec(), {1'b1, 69'b0});
    clear_model();
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      chk($sformatf("postrst_idle_%0d", i), obs_vec(), exp_vec(0));
      tick();
    end
    do_start();
    run_seq("zeros", 1'b0);

    // Write and start together, then an out-of-range operand index.
    wr_word(1'b0, 1'b1, 3'd0, 16'd7, 1'b1);
    run_seq("wr_start", 1'b0);
    wr_word(1'b0, 1'b0, 3'd5, 16'hBEEF, 1'b0);
    do_start();
    run_seq("oob_idx", 1'b0);

    // Randomized contents, including upper weight-index bits and dropped indices.
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 10; n++)
        wr_word(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
      do_start();
      run_seq($sformatf("rand%0d", r), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_feeder_2x2.md
Name: sa_feeder_2x2

Overview:
- Transmit-side sequencer for the 2x2 systolic array. It buffers one weight block (2x2) and one streaming operand block (2 lanes x DEPTH) written through a valid/ready port.
- On start it preloads the weights through the array's FDi path with load asserted. It then streams row operands onto RD_0/RD_1 with the one-cycle row skew and per-column strobes the array requires.
- Sits between the operand SRAM/DMA and the array's sa_* input ports.

Parameters:
- DATA_WIDTH, 16, width of every data word (must equal the array's DATA_WIDTH).
- DEPTH, 4, number of operands streamed per RD lane (2..2**IDX_W).
- IDX_W, 2, width of wr_idx; DEPTH <= 2**IDX_W.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid & wr_ready.
- wr_sel  input  1  0 = RD operand buffer, 1 = FD weight buffer.
- wr_lane  input  1  RD lane (sel=0) or weight column (sel=1).
- wr_idx  input  IDX_W  operand index (sel=0) or weight row in bit 0 (sel=1).
- wr_data  input  DATA_WIDTH  write data.
- start  input  1  begin one load+stream sequence.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- RD_0, RD_1  output  DATA_WIDTH  to sa_RD_0/sa_RD_1.
- FDi_0, FDi_1  output  DATA_WIDTH  to sa_FDi_0/sa_FDi_1.
- load  output  1  to sa_load.
- bd_PE_0, bd_PE_1  output  1  per-column valid strobes to sa_bd_PE_0/1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all buffer registers = 0; every output = 0 except wr_ready = 1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: wr_ready = 1; goes to LOAD at an edge where start = 1.
  - LOAD: 2 cycles.
  - STREAM: DEPTH+2 cycles.
  - DONE: 1 cycle.
  - Then back to IDLE.
- Timing, with start sampled at edge 0 (cycle n is the cycle after edge n-1):
  - Cycles 1-2 (LOAD): load = 1, busy = 1. FDi_0/FDi_1 = weight row 1 in cycle 1, then weight row 0 in cycle 2. RD = 0, bd_PE = 0.
  - Cycles 3 .. DEPTH+4 (STREAM, counter k = 0..DEPTH+1): busy = 1, load = 0, FDi = 0.
  - RD_0 = rd[0][k] when k < DEPTH, else 0.
  - RD_1 = rd[1][k-1] when 1 <= k <= DEPTH, else 0.
  - bd_PE_0 = 1 for k = 0..DEPTH; bd_PE_1 = 1 for k = 1..DEPTH+1.
  - Cycle DEPTH+5 (DONE): done = 1, busy = 0, all data and strobes = 0.
  - Start-to-done latency is DEPTH+5 cycles.
- Write interface:
  - wr_ready = 1 only in IDLE; it is 0 in LOAD, STREAM and DONE. Writes are never queued.
  - sel=0 with wr_idx >= DEPTH: the handshake completes and the data is dropped.
  - sel=1: only wr_idx[0] is used; the upper bits are ignored.
- Simultaneous events:
  - wr_valid and start in the same IDLE cycle: the write is committed and the sequence starts. The new value is used, because buffers are first read at edge 0.
  - start in LOAD, STREAM or DONE is ignored; it is not latched.
  - Same-index rewrites: last write wins.
- Buffers persist across sequences; repeating start replays the same data.
- Reset mid-sequence: outputs go to 0 immediately, the buffers are cleared, no done pulse is produced, and the FSM is in IDLE after release.

Test Plan:
1. Assert rst for 3 cycles, then release. Required: all outputs 0 during reset; wr_ready = 1 and busy = 0 after release.
2. DEPTH=4. Write weights row0 = (3,4), row1 = (5,6); lane0 = {1,2,3,4}; lane1 = {5,6,7,8}; then pulse start. Required:
   - cycles 1-2: load = 1, FDi = (5,6) then (3,4);
   - cycles 3-8: RD_0 = 1,2,3,4,0,0 and RD_1 = 0,5,6,7,8,0;
   - bd_PE_0 = 1,1,1,1,1,0 and bd_PE_1 = 0,1,1,1,1,1;
   - done = 1 only in cycle 9.
3. During scenario 2, drive wr_valid with data 99 to lane0 idx0 and pulse start in cycles 2, 5 and 9. Required: wr_ready = 0 and no new sequence. A replay started in IDLE afterwards still shows RD_0 first value = 1.
4. Assert rst in cycle 5 of scenario 2. Required: outputs 0 immediately and no done pulse. A new start after release produces all-zero RD/FDi with the normal strobes.
5. Raise wr_valid (lane1 idx0 = 7) and start in the same IDLE cycle. Required: RD_1 = 7 at stream k = 1. Then write idx = 5 with IDX_W=3, DEPTH=4. Required: the handshake completes and the streams are unchanged.
